// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// The result register holds {remainder, quotient}; div_ready qualifies it in DONE.
module div_unit #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_valid,
  input  logic              div_32,
  input  logic              div_signed,
  input  logic [XLEN-1:0]   dividend,
  input  logic [XLEN-1:0]   divisor,
  input  logic              hold,
  input  logic              flush,
  output logic              div_ready,
  output logic [2*XLEN-1:0] div_result
);
  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic            accept, step;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dq;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            sign_q, sign_r, is32;

  // W results are sign-extended from bit HW-1 of each half.
  function automatic logic [2*XLEN-1:0] fmt(input logic [XLEN-1:0] q,
                                            input logic [XLEN-1:0] r,
                                            input logic            w);
    if (w) fmt = {{HW{r[HW-1]}}, r[HW-1:0], {HW{q[HW-1]}}, q[HW-1:0]};
    else   fmt = {r, q};
  endfunction

  // operand decode at accept
  logic [XLEN-1:0] a_n, b_n, a_abs, b_abs, a_abs_f, b_abs_f;
  logic            a_neg, b_neg, b_zero, ovf;

  always_comb begin
    a_n     = div_32 ? {{HW{1'b0}}, dividend[HW-1:0]} : dividend;
    b_n     = div_32 ? {{HW{1'b0}}, divisor[HW-1:0]}  : divisor;
    a_neg   = div_signed & (div_32 ? dividend[HW-1] : dividend[XLEN-1]);
    b_neg   = div_signed & (div_32 ? divisor[HW-1]  : divisor[XLEN-1]);
    a_abs_f = a_neg ? -a_n : a_n;
    b_abs_f = b_neg ? -b_n : b_n;
    a_abs   = div_32 ? {{HW{1'b0}}, a_abs_f[HW-1:0]} : a_abs_f;
    b_abs   = div_32 ? {{HW{1'b0}}, b_abs_f[HW-1:0]} : b_abs_f;
    b_zero  = (b_n == '0);
    if (div_32)
      ovf = div_signed && (a_n[HW-1:0] == {1'b1, {(HW-1){1'b0}}}) && (b_n[HW-1:0] == {HW{1'b1}});
    else
      ovf = div_signed && (a_n == {1'b1, {(XLEN-1){1'b0}}}) && (b_n == {XLEN{1'b1}});
  end

  // one restoring step; XLEN+1 bits is enough since rem < dvs
  logic [XLEN:0]   trial;
  logic            ge;
  logic [XLEN-1:0] rem_nxt, dq_nxt, q_fin, r_fin;

  always_comb begin
    trial   = {rem, dq[XLEN-1]} - {1'b0, dvs};
    ge      = ~trial[XLEN];
    rem_nxt = ge ? trial[XLEN-1:0] : {rem[XLEN-2:0], dq[XLEN-1]};
    dq_nxt  = {dq[XLEN-2:0], ge};
    q_fin   = sign_q ? -dq_nxt  : dq_nxt;
    r_fin   = sign_r ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (div_valid) begin
          accept    = 1'b1;
          state_nxt = (b_zero || ovf) ? DONE : BUSY;
        end
        BUSY: begin
          step = 1'b1;
          if (cnt == CW'(1)) state_nxt = DONE;
        end
        DONE:    if (!hold) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      dq         <= '0;
      rem        <= '0;
      dvs        <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      is32       <= 1'b0;
      div_result <= '0;
    end else if (accept) begin
      cnt    <= div_32 ? CW'(HW) : CW'(XLEN);
      dq     <= div_32 ? (a_abs << HW) : a_abs;
      rem    <= '0;
      dvs    <= b_abs;
      sign_q <= a_neg ^ b_neg;
      sign_r <= a_neg;
      is32   <= div_32;
      if (b_zero)   div_result <= fmt({XLEN{1'b1}}, a_n, div_32);
      else if (ovf) div_result <= fmt(a_n, '0, div_32);
    end else if (step) begin
      cnt <= cnt - CW'(1);
      dq  <= dq_nxt;
      rem <= rem_nxt;
      if (cnt == CW'(1)) div_result <= fmt(q_fin, r_fin, is32);
    end
  end

  assign div_ready = (state == DONE) && !flush;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, W sign extension, flush, hold, async reset.
module tb_div_unit;
  logic         clk, rst;
  logic         div_valid, div_32, div_signed, hold, flush;
  logic [63:0]  dividend, divisor;
  logic         div_ready;
  logic [127:0] div_result;

  int n_run, n_fail;

  div_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .div_valid(div_valid), .div_32(div_32),
    .div_signed(div_signed), .dividend(dividend), .divisor(divisor),
    .hold(hold), .flush(flush), .div_ready(div_ready), .div_result(div_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Call just after a negedge with the DUT idle. Inputs are scrambled after
  // accept so only the latched copies can produce the right answer.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic s, input logic [127:0] exp,
                        input int lat, input int nhold);
    int cyc;
    logic [127:0] snap;
    div_valid = 1'b1; div_32 = w; div_signed = s; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    dividend = 64'h5A5A_A5A5_0F0F_F0F0; divisor = 64'h1; div_32 = ~w; div_signed = ~s;
    cyc = 1;
    while (!div_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 128'(cyc), 128'(lat));
    chk({tag, " result"}, div_result, exp);
    div_valid = 1'b0;
    snap = div_result;
    if (nhold > 0) begin
      hold = 1'b1;
      for (int i = 0; i < nhold; i++) begin
        @(negedge clk);
        chk({tag, " hold ready"}, 128'(div_ready), 128'(1));
        chk({tag, " hold result"}, div_result, snap);
      end
      hold = 1'b0;
    end
    @(negedge clk);
    chk({tag, " ready drop"}, 128'(div_ready), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit saw;
    n_run = 0; n_fail = 0;
    rst = 1'b0; div_valid = 1'b0; div_32 = 1'b0; div_signed = 1'b0;
    dividend = '0; divisor = '0; hold = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("reset ready", 128'(div_ready), 128'(0));
    chk("reset result", div_result, 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_op("divu 100/7", 64'd100, 64'd7, 1'b0, 1'b0, {64'd2, 64'd14}, 65, 0);
    run_op("div -7/2", -64'sd7, 64'd2, 1'b0, 1'b1,
           {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD}, 65, 0);
    run_op("div 7/-2", 64'd7, -64'sd2, 1'b0, 1'b1,
           {64'd1, 64'hFFFF_FFFF_FFFF_FFFD}, 65, 0);
    run_op("div 5/0", 64'd5, 64'd0, 1'b0, 1'b1,
           {64'd5, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 0);
    run_op("div ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1,
           {64'd0, 64'h8000_0000_0000_0000}, 1, 0);
    run_op("divw ovf", 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
           {64'd0, 64'hFFFF_FFFF_8000_0000}, 1, 0);
    run_op("divuw ffffffff/2", 64'hABCD_0000_FFFF_FFFF, 64'h9999_0000_0000_0002, 1'b1, 1'b0,
           {64'd1, 64'h0000_0000_7FFF_FFFF}, 33, 0);
    run_op("divw -100/7", 64'h0000_0000_FFFF_FF9C, 64'd7, 1'b1, 1'b1,
           {64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2}, 33, 0);
    run_op("divuw x/0", 64'h0000_0001_8000_0000, 64'hFFFF_0000_0000_0000, 1'b1, 1'b0,
           {64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF}, 1, 0);
    run_op("divu max/16 hold", 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 1'b0, 1'b0,
           {64'd15, 64'h0FFF_FFFF_FFFF_FFFF}, 65, 3);

    // flush at cycle 20 of a 64-bit op, new op accepted at cycle 21
    div_valid = 1'b1; div_32 = 1'b0; div_signed = 1'b0; dividend = 64'd1000; divisor = 64'd3;
    @(posedge clk);
    saw = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (div_ready) saw = 1'b1;
    end
    flush = 1'b1; div_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush ready seen", 128'(saw), 128'(0));
    chk("flush ready c21", 128'(div_ready), 128'(0));
    run_op("divu 9/3 after flush", 64'd9, 64'd3, 1'b0, 1'b0, {64'd0, 64'd3}, 65, 0);

    // async reset mid-BUSY
    div_valid = 1'b1; div_32 = 1'b0; div_signed = 1'b0; dividend = 64'd77; divisor = 64'd5;
    @(posedge clk);
    repeat (10) @(negedge clk);
    div_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async rst ready", 128'(div_ready), 128'(0));
    chk("async rst result", div_result, 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_op("divu 77/5 after rst", 64'd77, 64'd5, 1'b0, 1'b0, {64'd2, 64'd15}, 65, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
